d_cache_nway: RTL and testbench

Parametrised N-way set-associative, write-through, no-write-allocate data cache with integrated tag/valid/LRU storage and a miss-fill state machine. Sits between the processor memory stage and the unified memory port. It replaces the fixed 2-way array-only cache, whose hit/miss control lived outside the block.

---
 rtl/d_cache_nway.sv | 239 +++++++++++++++++++++++
 tb/tb_d_cache_nway.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_nway.sv
// N-way set-associative, write-through, no-write-allocate data cache with
// tag/valid/LRU storage and a blocking miss-fill state machine.
module d_cache_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic              flush,
    output logic [15:0]       rsp_rdata,
    output logic              stall,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W = WAY_W;

    typedef enum logic [1:0] {IDLE, FILL_REQ, FILL} state_t;

    logic [15:0]      data_mem [WAYS][SETS*WORDS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [AGE_W-1:0] age_q    [SETS][WAYS];

    state_t           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic [15:0]      hit_count_q, hit_count_d;
    logic [15:0]      miss_count_q, miss_count_d;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    assign req_off = req_addr[OFF_W:1];
    assign req_idx = req_addr[OFF_W+IDX_W:OFF_W+1];
    assign req_tag = req_addr[ADDR_W-1:OFF_W+IDX_W+1];

    logic [WAYS-1:0]  hit_vec;
    logic [15:0]      way_rdata [WAYS];
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [15:0]      hit_data;
    logic [WAY_W-1:0] victim;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign hit_vec[gi]   = valid_q[req_idx][gi] && (tag_mem[gi][req_idx] == req_tag);
        assign way_rdata[gi] = data_mem[gi][{req_idx, req_off}];
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_way  = WAY_W'(w);
                hit_data = way_rdata[w];
            end
        end
    end

    // Oldest way first, then overridden by the lowest-index invalid way.
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (age_q[req_idx][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim = WAY_W'(w);
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic               lru_en;
    logic [IDX_W-1:0]   lru_idx;
    logic [WAY_W-1:0]   lru_way;
    logic               data_we;
    logic [WAY_W-1:0]   data_way;
    logic [IDX_W+OFF_W-1:0] data_addr;
    logic [15:0]        data_wdata;
    logic               fill_done;
    logic               flush_en;

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        fill_idx_d    = fill_idx_q;
        fill_tag_d    = fill_tag_q;
        beat_d        = beat_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        stall         = 1'b0;
        rsp_rdata     = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_addr      = {fill_tag_q, fill_idx_q, {(OFF_W+1){1'b0}}};
        mem_wdata     = req_wdata;
        lru_en        = 1'b0;
        lru_idx       = req_idx;
        lru_way       = hit_way;
        data_we       = 1'b0;
        data_way      = hit_way;
        data_addr     = {req_idx, req_off};
        data_wdata    = req_wdata;
        fill_done     = 1'b0;
        flush_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    stall    = 1'b1;
                    flush_en = 1'b1;
                end else if (req_valid && req_we) begin
                    mem_req_valid = 1'b1;
                    mem_req_we    = 1'b1;
                    mem_addr      = req_addr;
                    stall         = !mem_req_ready;
                    if (mem_req_ready && hit) begin
                        data_we     = 1'b1;
                        lru_en      = 1'b1;
                        hit_count_d = sat_inc(hit_count_q);
                    end
                end else if (req_valid) begin
                    if (hit) begin
                        rsp_rdata   = hit_data;
                        lru_en      = 1'b1;
                        hit_count_d = sat_inc(hit_count_q);
                    end else begin
                        stall        = 1'b1;
                        victim_d     = victim;
                        fill_idx_d   = req_idx;
                        fill_tag_d   = req_tag;
                        miss_count_d = sat_inc(miss_count_q);
                        state_d      = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_rsp_valid) begin
                    data_we    = 1'b1;
                    data_way   = victim_q;
                    data_addr  = {fill_idx_q, beat_q};
                    data_wdata = mem_rdata;
                    beat_d     = beat_q + OFF_W'(1);
                    if (beat_q == OFF_W'(WORDS - 1)) begin
                        fill_done = 1'b1;
                        lru_en    = 1'b1;
                        lru_idx   = fill_idx_q;
                        lru_way   = victim_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            fill_idx_q   <= '0;
            fill_tag_q   <= '0;
            beat_q       <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            fill_idx_q   <= fill_idx_d;
            fill_tag_q   <= fill_tag_d;
            beat_q       <= beat_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Touched way becomes age 0; every way younger than its old age ages by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            if (flush_en) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (fill_done) begin
                valid_q[fill_idx_q][victim_q] <= 1'b1;
            end
            if (lru_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == lru_way)
                        age_q[lru_idx][w] <= '0;
                    else if (age_q[lru_idx][w] < age_q[lru_idx][lru_way])
                        age_q[lru_idx][w] <= age_q[lru_idx][w] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_way][data_addr] <= data_wdata;
        if (fill_done) tag_mem[victim_q][fill_idx_q] <= fill_tag_q;
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
endmodule

// File: tb/tb_d_cache_nway.sv
// Directed bench for d_cache_nway: miss fill, hits, LRU eviction, stores,
// flush and asynchronous reset during a fill.
module tb_d_cache_nway;
    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, flush;
    logic [15:0] req_addr, req_wdata;
    logic [15:0] rsp_rdata;
    logic        stall;
    logic        mem_req_valid, mem_req_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_req_ready, mem_rsp_valid;
    logic [15:0] mem_rdata;
    logic [15:0] hit_count, miss_count;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;

    d_cache_nway #(.WAYS(2), .SETS(64), .WORDS(WORDS), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush),
        .rsp_rdata(rsp_rdata), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && mem_req_valid && mem_req_we && mem_req_ready) wr_cnt <= wr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Load; on a miss, serve the fill: ready after wait_cyc cycles, beat i = base+i.
    task automatic do_load(input string tag, input logic [15:0] addr, input logic [15:0] base,
                           input int wait_cyc, input logic [15:0] exp, input logic exp_miss);
        int stalls;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; mem_req_ready = 1'b0;
        #1;
        check_eq({tag, "_miss"}, stall, exp_miss);
        if (stall) begin
            stalls = 1;
            @(negedge clk);
            for (int c = 0; c <= wait_cyc; c++) begin
                mem_req_ready = (c == wait_cyc);
                #1;
                stalls = stalls + (stall ? 1 : 0);
                if (c == 0) begin
                    check_eq({tag, "_mreq"}, {mem_req_valid, mem_req_we}, 2'b10);
                    check_eq({tag, "_maddr"}, mem_addr, addr & 16'hFFF0);
                end
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = base + 16'(i);
                #1;
                stalls = stalls + (stall ? 1 : 0);
                @(negedge clk);
            end
            mem_rsp_valid = 1'b0;
            #1;
            check_eq({tag, "_stallcyc"}, stalls, 2 + wait_cyc + WORDS);
            check_eq({tag, "_replay"}, stall, 1'b0);
        end
        check_eq({tag, "_rdata"}, rsp_rdata, exp);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [15:0] addr, input logic [15:0] data,
                            input int wait_cyc);
        int stalls;
        stalls = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
        for (int c = 0; c <= wait_cyc; c++) begin
            mem_req_ready = (c == wait_cyc);
            #1;
            stalls = stalls + (stall ? 1 : 0);
            if (c == 0) begin
                check_eq({tag, "_mreq"}, {mem_req_valid, mem_req_we}, 2'b11);
                check_eq({tag, "_maddr"}, mem_addr, addr);
                check_eq({tag, "_mwdata"}, mem_wdata, data);
            end
            if (c < wait_cyc) @(negedge clk);
        end
        check_eq({tag, "_stallcyc"}, stalls, wait_cyc);
        @(negedge clk);
        mem_req_ready = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_mreq", mem_req_valid, 1'b0);
        check_eq("rst_rdata", rsp_rdata, 16'h0);
        check_eq("rst_cnt", {hit_count, miss_count}, 32'h0);

        // 1: cold miss with a two-cycle handshake wait
        do_load("t1", 16'h0040, 16'h1000, 2, 16'h1000, 1'b1);
        #1;
        check_eq("t1_miss_cnt", miss_count, 16'd1);
        check_eq("t1_hit_cnt", hit_count, 16'd1);

        // 2: same block, word 3
        do_load("t2", 16'h0046, 16'h0000, 0, 16'h1003, 1'b0);
        #1;
        check_eq("t2_hit_cnt", hit_count, 16'd2);

        // 3: LRU eviction within set 4
        do_load("t3a", 16'h0440, 16'h2000, 0, 16'h2000, 1'b1);
        do_load("t3b", 16'h0040, 16'h0000, 0, 16'h1000, 1'b0);
        do_load("t3c", 16'h0840, 16'h3000, 1, 16'h3000, 1'b1);
        do_load("t3d", 16'h0040, 16'h0000, 0, 16'h1000, 1'b0);
        do_load("t3e", 16'h0440, 16'h2000, 0, 16'h2000, 1'b1);
        #1;
        check_eq("t3_cnt", {hit_count, miss_count}, {16'd7, 16'd4});

        // 4: store hit with back-pressure, then store miss
        do_store("t4a", 16'h0042, 16'hBEEF, 3);
        #1;
        check_eq("t4a_wr", wr_cnt, 1);
        check_eq("t4a_hit_cnt", hit_count, 16'd8);
        do_load("t4b", 16'h0042, 16'h0000, 0, 16'hBEEF, 1'b0);
        do_store("t4c", 16'h2000, 16'h1234, 0);
        #1;
        check_eq("t4c_wr", wr_cnt, 2);
        check_eq("t4c_hit_cnt", hit_count, 16'd9);
        do_load("t4d", 16'h2000, 16'h4000, 0, 16'h4000, 1'b1);
        #1;
        check_eq("t4_cnt", {hit_count, miss_count}, {16'd10, 16'd5});

        // 5: flush wins over a pending load
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
        #1;
        check_eq("t5_stall", stall, 1'b1);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        check_eq("t5_hit_cnt", hit_count, 16'd10);
        do_load("t5", 16'h0040, 16'h1000, 0, 16'h1000, 1'b1);

        // 6: reset after three fill beats
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0440; mem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t6_fillreq", mem_req_valid, 1'b1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = 16'hDE00 + 16'(i);
            @(negedge clk);
        end
        #1;
        check_eq("t6_in_fill", stall, 1'b1);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check_eq("t6_async_stall", stall, 1'b0);
        check_eq("t6_async_mreq", mem_req_valid, 1'b0);
        check_eq("t6_async_cnt", {hit_count, miss_count}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        do_load("t6_reload", 16'h0446, 16'h5000, 1, 16'h5003, 1'b1);
        do_load("t6_cold", 16'h0040, 16'h6000, 0, 16'h6000, 1'b1);
        #1;
        check_eq("t6_cnt", {hit_count, miss_count}, {16'd2, 16'd2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
